and_vec_loader: RTL



---
 rtl/and_loader_pkg.sv | 23 ++
 rtl/and_hold_timer.sv | 34 +++
 rtl/and_vec_loader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/and_loader_pkg.sv
// Shared types and width helpers for the AND-gate vector loader.
//   state_e    : output FSM states
//   cnt_width  : bit-count register width for a given vector width
//   hold_width : hold-counter width for a given settle time
package and_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    STABLE = 2'd2
  } state_e;

  // Counter must represent 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Hold counter only ever holds 0..hold_cycles-1.
  function automatic int unsigned hold_width(input int unsigned hold_cycles);
    return (hold_cycles > 2) ? $clog2(hold_cycles) : 1;
  endfunction

endpackage

// File: rtl/and_hold_timer.sv
// Loadable down-counter timing the settle window after a vector transfer.
//   clk, rst_n : clock, async active-low reset
//   load       : load counter with load_val
//   load_val   : reload value
//   run        : count down while high; counter stops at zero
//   done       : counter is zero while running
module and_hold_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         done
);

  logic [W-1:0] hold;

  // Down-counter that saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (load) begin
      hold <= load_val;
    end else if (run && (hold != '0)) begin
      hold <= hold - W'(1);
    end
  end

  // Decoded directly from the counter register.
  assign done = run && (hold == '0);

endmodule

// File: rtl/and_vec_loader.sv
// Serial-to-parallel feeder for a multi-input AND gate. Bits are collected
// LSB first into a shadow register, transferred to vec_out in one edge, and
// vec_out is flagged stable HOLD_CYCLES edges after the transfer. The next
// vector may be collected while the current one settles.
//   clk, rst_n   : clock, async active-low reset
//   bit_in       : serial data bit, LSB first
//   bit_valid    : bit_in valid this cycle
//   bit_ready    : loader accepts a bit this cycle
//   clear        : synchronous flush of the partially collected shadow
//   vec_out      : vector driving the gate input bus
//   vec_stable   : vec_out held for at least HOLD_CYCLES cycles
//   busy         : shadow non-empty or output settling
// Optional (AND_LOADER_SAMPLE_EN defined):
//   gate_out     : AND gate result
//   sample_q     : gate_out captured on entry to STABLE
//   sample_valid : one-cycle pulse when sample_q updates
module and_vec_loader #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  input  logic             clear,
  output logic [WIDTH-1:0] vec_out,
  output logic             vec_stable,
  output logic             busy
`ifdef AND_LOADER_SAMPLE_EN
  ,
  input  logic             gate_out,
  output logic             sample_q,
  output logic             sample_valid
`endif
);

  import and_loader_pkg::*;

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam int unsigned HW = hold_width(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_FULL  = CW'(WIDTH);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

  state_e           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] shadow, shadow_next;
  logic             full_c, accept_c, xfer_c, settle_c, hold_done_c;

  assign full_c   = (cnt == CNT_FULL);
  assign settle_c = (state == SETTLE);
  // clear beats both an accept and a pending transfer.
  assign accept_c = bit_valid && !full_c && !clear;
  assign xfer_c   = full_c && !clear && !settle_c;

  and_hold_timer #(
    .W(HW)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (xfer_c),
    .load_val (HOLD_INIT),
    .run      (settle_c),
    .done     (hold_done_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus next collect-side values.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    shadow_next = shadow;

    if (clear || xfer_c) begin
      cnt_next    = '0;
      shadow_next = '0;
    end else if (accept_c) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (cnt == CW'(i)) begin
          shadow_next[i] = bit_in;
        end
      end
      cnt_next = cnt + CW'(1);
    end

    unique case (state)
      IDLE, STABLE: if (xfer_c) state_next = SETTLE;
      SETTLE:       if (hold_done_c) state_next = STABLE;
      default:      state_next = IDLE;
    endcase
  end

  // Collect registers and registered outputs, derived from next values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      shadow     <= '0;
      vec_out    <= '0;
      vec_stable <= 1'b0;
      bit_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      shadow     <= shadow_next;
      if (xfer_c) begin
        vec_out <= shadow;
      end
      vec_stable <= (state_next == STABLE);
      bit_ready  <= (cnt_next != CNT_FULL);
      busy       <= (cnt_next != '0) || (state_next == SETTLE);
    end
  end

`ifdef AND_LOADER_SAMPLE_EN
  logic enter_stable_c;

  assign enter_stable_c = settle_c && hold_done_c;

  // Capture the gate result once the vector has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q     <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= enter_stable_c;
      if (enter_stable_c) begin
        sample_q <= gate_out;
      end
    end
  end
`else
  // No gate sampling path in this build.
`endif

endmodule
